// File: rtl/imem_loader.sv
// Loads a big-endian byte stream into instruction memory.
// The core is held in reset until the load finishes.
module imem_loader #(
   parameter int ADDR_W = 5,
   parameter int DEPTH  = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              in_valid,
   input  logic [7:0]        in_data,
   input  logic              in_last,
   output logic              in_ready,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic              core_reset,
   output logic              busy,
   output logic              done,
   output logic              error,
   output logic [ADDR_W:0]   word_count
);

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE} state_t;

   localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W+1)'(DEPTH - 1);
   localparam logic [ADDR_W:0] ONE      = (ADDR_W+1)'(1);

   state_t            state;
   logic [1:0]        byte_idx;
   logic [31:0]       pack;
   logic [ADDR_W:0]   word_idx;
   logic              final_wr;
   logic              err_wr;
   logic [31:0]       word_n;

   function automatic logic [31:0] insert_byte(input logic [31:0] w,
                                               input logic [1:0]  idx,
                                               input logic [7:0]  b);
      logic [31:0] r;
      r = w;
      case (idx)
         2'd0:    r[31:24] = b;
         2'd1:    r[23:16] = b;
         2'd2:    r[15:8]  = b;
         default: r[7:0]   = b;
      endcase
      return r;
   endfunction

   // pack is cleared after every word, so an early in_last leaves zero padding
   assign word_n = insert_byte(pack, byte_idx, in_data);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= S_IDLE;
         byte_idx   <= '0;
         pack       <= '0;
         word_idx   <= '0;
         final_wr   <= 1'b0;
         err_wr     <= 1'b0;
         in_ready   <= 1'b0;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         core_reset <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         error      <= 1'b0;
         word_count <= '0;
      end else begin
         mem_we <= 1'b0;
         case (state)
            S_LOAD: begin
               if (mem_we) begin
                  word_count <= word_count + ONE;
                  if (final_wr) begin
                     state      <= S_DONE;
                     busy       <= 1'b0;
                     done       <= 1'b1;
                     core_reset <= 1'b1;
                     error      <= err_wr;
                  end
               end
               if (in_valid && in_ready) begin
                  if (byte_idx == 2'd3 || in_last) begin
                     mem_we    <= 1'b1;
                     mem_addr  <= word_idx[ADDR_W-1:0];
                     mem_wdata <= word_n;
                     word_idx  <= word_idx + ONE;
                     pack      <= '0;
                     byte_idx  <= '0;
                     // Final word: stop accepting during its write cycle
                     if (in_last || word_idx == LAST_IDX) begin
                        in_ready <= 1'b0;
                        final_wr <= 1'b1;
                        err_wr   <= in_last ? (byte_idx != 2'd3) : 1'b1;
                     end
                  end else begin
                     pack     <= word_n;
                     byte_idx <= byte_idx + 2'd1;
                  end
               end
            end
            S_IDLE, S_DONE: begin
               if (start) begin
                  state      <= S_LOAD;
                  in_ready   <= 1'b1;
                  busy       <= 1'b1;
                  done       <= 1'b0;
                  core_reset <= 1'b0;
                  byte_idx   <= '0;
                  pack       <= '0;
                  word_idx   <= '0;
                  word_count <= '0;
                  error      <= 1'b0;
                  final_wr   <= 1'b0;
                  err_wr     <= 1'b0;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
Program loader upstream of the single-cycle core's instruction memory. Takes a byte stream over a valid/ready handshake and packs it big-endian into 32-bit words. Writes the words sequentially into the instruction memory write port. Holds the core in reset until the load completes, which replaces hierarchical preloading of the instruction memory.

Parameters:
ADDR_W, 5, word-address width of the instruction memory
DEPTH, 32, number of instruction words the loader may write (must be ≤ 2**ADDR_W)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low; 0 = reset
start  input  1  begin a load; sampled in IDLE and DONE only
in_valid  input  1  byte-stream valid
in_data  input  8  byte-stream data
in_last  input  1  qualifies the final byte of the program
in_ready  output  1  loader accepts a byte this cycle
mem_we  output  1  instruction-memory write strobe, one cycle per word
mem_addr  output  ADDR_W  word address of the current write
mem_wdata  output  32  word being written
core_reset  output  1  active-low reset to the core; 1 releases the core
busy  output  1  load in progress
done  output  1  load finished; core released
error  output  1  sticky per load: partial final word or overflow
word_count  output  ADDR_W+1  words written in the current or last load

Behaviour:
- Async reset (reset=0) sets all outputs to 0: in_ready, mem_we, mem_addr, mem_wdata, core_reset, busy, done, error, word_count. It also clears the byte index and puts the state machine in IDLE. Memory contents are not cleared.
- States: IDLE, LOAD, DONE. All outputs are registered.
- IDLE: core_reset=0 and in_ready=0. When start=1, move to LOAD on the next edge and clear the byte index, word index, word_count and error.
- LOAD: in_ready=1 and busy=1. A byte is accepted on an edge where in_valid & in_ready. The byte index advances 0..3.
  - Byte 0 goes to bits 31:24, byte 1 to 23:16, byte 2 to 15:8, byte 3 to 7:0.
  - On the edge that accepts byte 3, the packed word is transferred to a write register.
  - In the following cycle: mem_we=1, mem_addr=word index, mem_wdata=word. word_count increments at that cycle's end.
  - Latency is 1 cycle from acceptance of the 4th byte to mem_we.
  - in_ready stays 1 during the write cycle, so a full-rate stream gives one write every 4 cycles with no stall.
- in_last on byte 3: that word is written normally, then DONE is entered on the edge ending the write cycle.
- in_last on byte 0–2: the unfilled low bytes are zero-padded and the word is written in the next cycle. error is set to 1, then DONE is entered.
- Overflow: if word DEPTH-1 is written and in_last was not set on its final byte, the loader enters DONE with error=1. in_ready=0 from that point, and further bytes are neither accepted nor written.
- start asserted during LOAD is ignored.
- in_valid=0 inserts bubbles. The partial word and byte index are held indefinitely.
- DONE: in_ready=0, busy=0, done=1, core_reset=1. For a final write in cycle N, done and core_reset are 1 from cycle N+1. word_count and error hold.
- start=1 in DONE: on the next edge, core_reset=0, done=0, and the state machine moves to LOAD with counters and error cleared, so the core is re-held in reset.
- Reset mid-load: immediate return to IDLE and the core is held in reset. Words already written remain in memory.
- mem_addr wraps never: word index is bounded by DEPTH.

Test Plan:
- Reset low for 3 cycles, then high with no start -> all outputs 0, core_reset stays 0.
- start, then bytes 21 08 00 01 with in_last on 01 -> one mem_we cycle with addr 0 and wdata 0x21080001. Next cycle: done=1, core_reset=1, word_count=1, error=0.
- start, then 11 back-to-back addi words (44 bytes) at full rate, in_last on byte 44 -> writes at addr 0..10 spaced exactly 4 cycles apart, all 0x21080001; in_ready never drops; word_count=11.
- start, then bytes AA BB with in_last on BB -> write of 0xAABB0000 at addr 0, error=1, done=1.
- DEPTH=4, stream of 20 bytes with no in_last -> 4 writes (addr 0..3), then in_ready=0, error=1, done=1, word_count=4; bytes 17–20 are not written.
- Reset pulsed low after 6 bytes -> outputs return to 0 asynchronously and the state machine is in IDLE. A restart loads from addr 0 with error=0.
